// File: rtl/i_cache_dm_if.sv
// SRAM-like instruction bus between the cache (master) and the AXI bridge (slave).
interface i_cache_dm_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache. Hits return data in the same cycle; misses
// refill a whole line with sequential single-word bus reads; kseg1 fetches
// bypass the cache with a single bus read held across pipeline stalls.
module i_cache_dm #(
    parameter int SETS           = 64,
    parameter int LINE_WORDS     = 4,
    parameter bit UNCACHED_KSEG1 = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inst_sram_en,
    input  logic [31:0]  inst_sram_addr,
    output logic [31:0]  inst_sram_rdata,
    output logic         i_stall,
    input  logic         longest_stall,
    i_cache_dm_if.master bus
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int OFF_W   = WORD_W + 2;
    localparam int TAG_W   = 32 - OFF_W - INDEX_W;
    localparam int LINE_W  = TAG_W + INDEX_W;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RF_REQ,
        RF_WAIT,
        UC_REQ,
        UC_WAIT,
        UC_DONE
    } state_e;

    state_e            state_q,   state_d;
    logic [LINE_W-1:0] rf_line_q, rf_line_d;
    logic [WORD_W-1:0] cnt_q,     cnt_d;
    logic [31:0]       uc_save_q, uc_save_d;
    logic [SETS-1:0]   valid_q,   valid_d;

    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [31:0]       data_mem [SETS*LINE_WORDS];

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [WORD_W-1:0]  req_word;
    logic [TAG_W-1:0]   rf_tag;
    logic [INDEX_W-1:0] rf_index;
    logic               cached;
    logic               hit;
    logic               word_ret;
    logic               data_we;
    logic               tag_we;
    logic               unused_addr_lsbs;

    assign req_tag   = inst_sram_addr[31:OFF_W+INDEX_W];
    assign req_index = inst_sram_addr[OFF_W+INDEX_W-1:OFF_W];
    assign req_word  = inst_sram_addr[OFF_W-1:2];
    assign rf_tag    = rf_line_q[LINE_W-1:INDEX_W];
    assign rf_index  = rf_line_q[INDEX_W-1:0];

    // Fetch addresses are word aligned; the byte offset carries no information.
    assign unused_addr_lsbs = ^inst_sram_addr[1:0];

    assign cached = !(UNCACHED_KSEG1 && (inst_sram_addr[31:29] == 3'b101));
    assign hit    = inst_sram_en && cached && valid_q[req_index]
                    && (tag_mem[req_index] == req_tag);

    // Bus side: a read request is only ever raised from the two request states.
    assign bus.inst_req   = (state_q == RF_REQ) || (state_q == UC_REQ);
    assign bus.inst_addr  = (state_q == UC_REQ) ? inst_sram_addr : {rf_line_q, cnt_q, 2'b00};
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = 2'b10;
    assign bus.inst_wdata = 32'h0;

    // Fetch side: UC_DONE presents the saved uncached word, IDLE hits present the line.
    assign i_stall = inst_sram_en && !((state_q == IDLE) && hit) && (state_q != UC_DONE);
    assign inst_sram_rdata = (state_q == UC_DONE) ? uc_save_q :
                             hit ? data_mem[{req_index, req_word}] : 32'h0;

    // Next-state logic: refill sequencing, uncached single read, valid bookkeeping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        rf_line_d = rf_line_q;
        cnt_d     = cnt_q;
        uc_save_d = uc_save_q;
        valid_d   = valid_q;
        word_ret  = 1'b0;
        data_we   = 1'b0;
        tag_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (inst_sram_en) begin
                    if (!cached) begin
                        state_d = UC_REQ;
                    end else if (!hit) begin
                        // Invalidate up front so a partially refilled line never hits.
                        rf_line_d          = {req_tag, req_index};
                        cnt_d              = '0;
                        valid_d[req_index] = 1'b0;
                        state_d            = RF_REQ;
                    end
                end
            end
            RF_REQ: begin
                if (bus.inst_addr_ok) begin
                    if (bus.inst_data_ok) word_ret = 1'b1;
                    else                  state_d  = RF_WAIT;
                end
            end
            RF_WAIT: begin
                if (bus.inst_data_ok) word_ret = 1'b1;
            end
            UC_REQ: begin
                if (bus.inst_addr_ok) begin
                    if (bus.inst_data_ok) begin
                        uc_save_d = bus.inst_rdata;
                        state_d   = UC_DONE;
                    end else begin
                        state_d = UC_WAIT;
                    end
                end
            end
            UC_WAIT: begin
                if (bus.inst_data_ok) begin
                    uc_save_d = bus.inst_rdata;
                    state_d   = UC_DONE;
                end
            end
            UC_DONE: begin
                if (!longest_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (word_ret) begin
            data_we = 1'b1;
            if (cnt_q == LAST_WORD) begin
                valid_d[rf_index] = 1'b1;
                tag_we            = 1'b1;
                state_d           = IDLE;
            end else begin
                cnt_d   = cnt_q + WORD_W'(1);
                state_d = RF_REQ;
            end
        end
    end

    // Control state registers; reset drops any refill in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            rf_line_q <= '0;
            cnt_q     <= '0;
            uc_save_q <= 32'h0;
            valid_q   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
            state_q   <= state_d;
            rf_line_q <= rf_line_d;
            cnt_q     <= cnt_d;
            uc_save_q <= uc_save_d;
            valid_q   <= valid_d;
        end
    end

    // Line storage: data words as they return, tag once the line is complete.
    always_ff @(posedge clk) begin
        // NOTE: the arrays have no reset; valid_q alone decides whether their contents are trusted.
        if (data_we) data_mem[{rf_index, cnt_q}] <= bus.inst_rdata;
        if (tag_we)  tag_mem[rf_index]           <= rf_tag;
    end
endmodule

// File: tb/tb_i_cache_dm.sv
// Randomized bench for i_cache_dm: a bus slave with random latency, a set-level
// reference model of the cache and a log of every accepted bus address.
module tb_i_cache_dm;
    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        i_stall;
    logic        longest_stall;

    i_cache_dm_if bus ();

    i_cache_dm #(
        .SETS           (64),
        .LINE_WORDS     (4),
        .UNCACHED_KSEG1 (1'b1)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (en),
        .inst_sram_addr  (addr),
        .inst_sram_rdata (rdata),
        .i_stall         (i_stall),
        .longest_stall   (longest_stall),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus slave ----------------
    logic [31:0] req_log [$];
    int          data_cnt   = 0;
    int          ret_cyc    = 0;
    bit          same_cycle = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    initial begin
        logic [31:0] a;
        bit          live;
        int          d;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            bus.inst_addr_ok = 1'b0;
            bus.inst_data_ok = 1'b0;
            if (resetn && bus.inst_req) begin
                live = 1'b1;
                d    = $urandom_range(0, 2);
                repeat (d) begin
                    @(negedge clk);
                    if (!bus.inst_req || !resetn) live = 1'b0;
                end
                if (live) begin
                    a = bus.inst_addr;
                    req_log.push_back(a);
                    bus.inst_addr_ok = 1'b1;
                    if (same_cycle) begin
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = mem_word(a);
                        data_cnt++;
                        ret_cyc = cyc + 1;
                    end else begin
                        @(negedge clk);
                        bus.inst_addr_ok = 1'b0;
                        d = $urandom_range(0, 2);
                        repeat (d) @(negedge clk);
                        bus.inst_data_ok = 1'b1;
                        bus.inst_rdata   = mem_word(a);
                        data_cnt++;
                        ret_cyc = cyc + 1;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          model_valid [64];
    logic [21:0] model_tag   [64];

    function automatic bit model_cached(input logic [31:0] a);
        return a[31:29] != 3'b101;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model_valid[i] = 1'b0;
    endtask

    task automatic check_consts(input string tag);
        check({tag, "_wr"},    32'(bus.inst_wr),    32'd0);
        check({tag, "_size"},  32'(bus.inst_size),  32'd2);
        check({tag, "_wdata"}, bus.inst_wdata,      32'd0);
    endtask

    // One fetch from IDLE, checked against the model. hold=1 leaves en high and
    // raises longest_stall once the data is presented.
    task automatic fetch(input logic [31:0] a, input bit hold);
        int base;
        int budget;
        int idx;
        bit exp_hit;
        @(negedge clk);
        en      = 1'b1;
        addr    = a;
        base    = req_log.size();
        idx     = int'(a[9:4]);
        exp_hit = model_cached(a) && model_valid[idx] && (model_tag[idx] == a[31:10]);
        #1;
        if (exp_hit) begin
            check("hit_stall", 32'(i_stall), 32'd0);
            check("hit_rdata", rdata, mem_word(a));
            check("hit_noreq", 32'(bus.inst_req), 32'd0);
        end else begin
            budget = 0;
            while (i_stall && budget < 300) begin
                @(negedge clk);
                #1;
                budget++;
            end
            check("miss_timeout", (budget < 300) ? 32'd1 : 32'd0, 32'd1);
            check("miss_release_cycle", cyc, ret_cyc);
            check("miss_rdata", rdata, mem_word(a));
            if (model_cached(a)) begin
                check("refill_nreq", req_log.size() - base, 32'd4);
                for (int w = 0; w < 4; w++) begin
                    if (base + w < req_log.size())
                        check("refill_addr", req_log[base + w], {a[31:4], 4'h0} + 32'(w * 4));
                end
                model_valid[idx] = 1'b1;
                model_tag[idx]   = a[31:10];
            end else begin
                check("uc_nreq", req_log.size() - base, 32'd1);
                if (base < req_log.size()) check("uc_addr", req_log[base], a);
            end
        end
        if (hold) longest_stall = 1'b1;
        else      en = 1'b0;
    endtask

    // Uncached result must stay presented with no new request while stalled.
    task automatic hold_check(input logic [31:0] a, input int n);
        int base;
        base = req_log.size();
        repeat (n) begin
            @(negedge clk);
            #1;
            check("hold_stall", 32'(i_stall), 32'd0);
            check("hold_rdata", rdata, mem_word(a));
            check("hold_req",   32'(bus.inst_req), 32'd0);
        end
        check("hold_noreq", req_log.size() - base, 32'd0);
        @(negedge clk);
        longest_stall = 1'b0;
        en            = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          base;
        int          budget;
        int          r;
        logic [31:0] a;
        logic [31:0] bases [4];
        logic [5:0]  idxs  [4];

        bases[0] = 32'h0000_0000; bases[1] = 32'h0000_1000;
        bases[2] = 32'h8000_0000; bases[3] = 32'h9FC0_0000;
        idxs[0]  = 6'd0; idxs[1] = 6'd1; idxs[2] = 6'h10; idxs[3] = 6'd63;

        resetn        = 1'b0;
        en            = 1'b0;
        addr          = 32'h0;
        longest_stall = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("reset_req",   32'(bus.inst_req), 32'd0);
        check("reset_stall", 32'(i_stall), 32'd0);
        check_consts("reset");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("idle_req",   32'(bus.inst_req), 32'd0);
        check("idle_stall", 32'(i_stall), 32'd0);
        check("idle_rdata", rdata, 32'd0);

        // Cold miss, then hit within the same line.
        fetch(32'h0000_0100, 1'b0);
        fetch(32'h0000_0108, 1'b0);

        // Conflict on index 0x10 evicts, so the original line misses again.
        fetch(32'h0000_1100, 1'b0);
        fetch(32'h0000_0100, 1'b0);
        fetch(32'h0000_0104, 1'b0);

        // Uncached fetch held across a 3-cycle pipeline stall, then re-fetched.
        fetch(32'hBFC0_0000, 1'b1);
        hold_check(32'hBFC0_0000, 3);
        fetch(32'hBFC0_0000, 1'b0);

        // addr_ok and data_ok together on every word.
        same_cycle = 1'b1;
        fetch(32'h0000_2000, 1'b0);
        fetch(32'h0000_200C, 1'b0);
        same_cycle = 1'b0;

        // Reset in the middle of a refill.
        @(negedge clk);
        en     = 1'b1;
        addr   = 32'h0000_4100;
        base   = data_cnt;
        budget = 0;
        while ((data_cnt - base) < 2 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("rst_refill_timeout", (budget < 200) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_req_drop", 32'(bus.inst_req), 32'd0);
        check_consts("rst_mid");
        en = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        resetn = 1'b1;
        fetch(32'h0000_0100, 1'b0);
        fetch(32'h0000_4100, 1'b0);
        fetch(32'h0000_010C, 1'b0);

        // Randomized mix of cached hits/misses/conflicts and uncached fetches.
        for (int it = 0; it < 150; it++) begin
            same_cycle = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r < 7) begin
                a = bases[$urandom_range(0, 3)] + {22'h0, idxs[$urandom_range(0, 3)], 4'h0}
                    + 32'($urandom_range(0, 3) * 4);
                fetch(a, 1'b0);
            end else begin
                a = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0000 : 32'hA000_0000;
                a = a + 32'($urandom_range(0, 255) * 4);
                if (r == 9) begin
                    fetch(a, 1'b1);
                    hold_check(a, $urandom_range(1, 4));
                end else begin
                    fetch(a, 1'b0);
                end
            end
            if (it % 25 == 0) check_consts("run");
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end
endmodule
